yuv_capture_sequencer: RTL and testbench
========================================

# yuv_capture_sequencer

Sequences the camera capture path ahead of the YUV 4:2:2 to 4:4:4 converter. Pairs the camera's 8-bit byte stream into 16-bit {Y, C} words and generates the pixel column index whose LSB selects Cb/Cr downstream. Also generates line index and frame/line markers from VSYNC/HREF. Runs armed or continuous frame capture under software start/stop.

## Interface
- H_ACTIVE, 640, accepted pixels per line; extra pixels dropped
- V_ACTIVE, 480, lines per frame
- iCLK  in  1  system clock
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  level; high arms capture, held high gives continuous frames
- iVSYNC  in  1  frame sync, active high, already synchronous to iCLK
- iHREF  in  1  line valid, active high
- iDE  in  1  byte strobe; iDATA valid when high
- iDATA  in  8  camera byte, order C,Y,C,Y… (Cb0 Y0 Cr1 Y1)
- iCLR  in  1  clears sticky status
- oYCbCr  out  16  {Y[15:8], C[7:0]}
- oX  out  10  pixel column of oYCbCr; even = Cb, odd = Cr
- oLINE  out  10  line index of oYCbCr
- oVALID  out  1  oYCbCr/oX/oLINE valid, one cycle per pixel
- oSOF  out  1  with oVALID on pixel (0,0)
- oEOL  out  1  one-cycle pulse per completed line
- oBUSY  out  1  state ≠ IDLE
- oERR_SHORT, oERR_LONG, oERR_ABORT  out  1 each  sticky status

## Operation
- States: IDLE → WAIT_FRAME on iSTART=1; WAIT_FRAME → WAIT_LINE on iVSYNC rising edge; WAIT_LINE → ACTIVE on iHREF=1; ACTIVE → WAIT_LINE on iHREF falling edge with line < V_ACTIVE−1; ACTIVE → FRAME_END when the falling edge completes line V_ACTIVE−1.
- FRAME_END lasts one cycle, then → WAIT_FRAME if iSTART=1, else → IDLE.
- iSTART low mid-frame: finish the current frame, then go to IDLE.
- Byte phase toggles on each iDE while in ACTIVE. Phase 0 latches C; phase 1 emits {iDATA, C}.
- Phase and column reset at every line start.
- Pixels with column ≥ H_ACTIVE are not emitted (oVALID stays low); oERR_LONG set.
- iHREF falling edge: oEOL pulses and the line counter increments.
  - Fewer than H_ACTIVE pixels in the line: oERR_SHORT set.
  - Odd trailing byte: discarded, oERR_SHORT set.
- iVSYNC rising edge in WAIT_LINE or ACTIVE: abort the frame and set oERR_ABORT.
  - Line and column reset to 0; → WAIT_LINE (new frame). No oEOL for the partial line.
- Sticky errors clear on iCLR or on an iSTART rising edge. Setting an error has priority over clearing it in the same cycle.
- Edges are detected against a one-cycle registered copy of iVSYNC/iHREF. Reset loads the registered copies with 0.

## Timing
- Reset: state IDLE; all outputs 0.
- oVALID asserts the cycle after the phase-1 iDE. oX/oLINE/oSOF are registered alongside it.
- oEOL asserts the cycle after iHREF is first sampled low.
  - If a pixel is emitted in the same cycle, both pulses appear together.
- iDE in the same cycle as the iHREF falling edge is ignored.
- iDE may assert every cycle, giving one pixel per 2 cycles sustained.
- oBUSY follows the registered state.

## Configuration
- YUV_SEQ_STATUS_EN defined: oERR_* and their detection logic are present.
- Not defined: oERR_* tied to 0 and iCLR ignored; capture behaviour is otherwise identical.

## Structure
- Package yuv_seq_pkg holds:
  - state enum (IDLE, WAIT_FRAME, WAIT_LINE, ACTIVE, FRAME_END)
  - coordinate width constant (10)
  - byte-phase type
- Sub-module sync_edge_detect: registers one input and outputs rise/fall pulses. Instantiated for iVSYNC and iHREF.

## Test plan
- Reset, then iSTART=1 with a 4×2 frame (H_ACTIVE=4, V_ACTIVE=2) and bytes 0x10..0x1F → oYCbCr = 0x1110, 0x1312, …; oX = 0,1,2,3; oSOF on the first word only; two oEOL pulses; state returns to WAIT_FRAME.
- Line with 6 pixels when H_ACTIVE=4 → 4 oVALID pulses, oERR_LONG=1, oLINE increments once.
- Line with 3 pixels + 1 odd byte → 3 oVALID pulses, oERR_SHORT=1; next line starts at oX=0, C phase.
- iVSYNC rising mid-line 1 → oERR_ABORT=1, no oEOL; next pixel emitted is (0,0) with oSOF.
- iSTART dropped mid-frame → frame completes, then oBUSY=0. iRST asserted mid-line → all outputs 0 immediately, state IDLE.
- iCLR pulse with errors set → all sticky flags 0. With the macro undefined → error flags stay 0 for all scenarios above.

Source files
------------

// File: rtl/yuv_seq_pkg.sv
// Shared types for the YUV capture sequencer: FSM states, coordinate width
// and the byte-phase type used when pairing camera bytes into {Y, C} words.
package yuv_seq_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_LINE,
        ACTIVE,
        FRAME_END
    } seq_state_t;

    typedef enum logic {
        PHASE_C = 1'b0,
        PHASE_Y = 1'b1
    } byte_phase_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one already-synchronous input and reports single-cycle rise/fall
// pulses by comparing the live input against its registered copy.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/yuv_capture_sequencer.sv
// Camera capture sequencer: pairs C,Y bytes into 16-bit words with column/line
// coordinates and frame markers. Sticky status is built only with YUV_SEQ_STATUS_EN.
module yuv_capture_sequencer
    import yuv_seq_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iVSYNC,
    input  logic        iHREF,
    input  logic        iDE,
    input  logic [7:0]  iDATA,
    input  logic        iCLR,
    output logic [15:0] oYCbCr,
    output logic [9:0]  oX,
    output logic [9:0]  oLINE,
    output logic        oVALID,
    output logic        oSOF,
    output logic        oEOL,
    output logic        oBUSY,
    output logic        oERR_SHORT,
    output logic        oERR_LONG,
    output logic        oERR_ABORT
);

    localparam coord_t H_MAX  = coord_t'(H_ACTIVE);
    localparam coord_t V_LAST = coord_t'(V_ACTIVE - 1);

    seq_state_t  state;
    seq_state_t  state_next;
    byte_phase_t phase;
    coord_t      col;
    coord_t      line;
    logic [7:0]  c_byte;

    logic vsync_rise;
    logic vsync_fall;
    logic href_rise;
    logic href_fall;
    logic unused_edges;

    logic abort;
    logic line_start;
    logic line_end;
    logic byte_en;

    sync_edge_detect u_vsync_edge (
        .clk  (iCLK),
        .rst  (iRST),
        .sig  (iVSYNC),
        .rise (vsync_rise),
        .fall (vsync_fall)
    );

    sync_edge_detect u_href_edge (
        .clk  (iCLK),
        .rst  (iRST),
        .sig  (iHREF),
        .rise (href_rise),
        .fall (href_fall)
    );

    assign unused_edges = vsync_fall ^ href_rise;

    // A VSYNC rise during a frame wins over every other event in that cycle,
    // and a byte arriving with the HREF falling edge is dropped.
    assign abort      = vsync_rise && (state == WAIT_LINE || state == ACTIVE);
    assign line_start = (state == WAIT_LINE) && !vsync_rise && iHREF;
    assign line_end   = (state == ACTIVE) && !vsync_rise && href_fall;
    assign byte_en    = (state == ACTIVE) && !vsync_rise && !href_fall && iDE;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:       if (iSTART) state_next = WAIT_FRAME;
            WAIT_FRAME: if (vsync_rise) state_next = WAIT_LINE;
            WAIT_LINE:  if (line_start) state_next = ACTIVE;
            ACTIVE: begin
                if (abort) begin
                    state_next = WAIT_LINE;
                end else if (line_end) begin
                    state_next = (line == V_LAST) ? FRAME_END : WAIT_LINE;
                end
            end
            FRAME_END:  state_next = iSTART ? WAIT_FRAME : IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Column saturates at H_ACTIVE so overlong lines never wrap back into
    // the visible range.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            phase  <= PHASE_C;
            col    <= '0;
            line   <= '0;
            c_byte <= '0;
            oYCbCr <= '0;
            oX     <= '0;
            oLINE  <= '0;
            oVALID <= 1'b0;
            oSOF   <= 1'b0;
            oEOL   <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            oSOF   <= 1'b0;
            oEOL   <= 1'b0;
            if (abort) begin
                line  <= '0;
                col   <= '0;
                phase <= PHASE_C;
            end else if (state == WAIT_FRAME && vsync_rise) begin
                line <= '0;
            end else if (line_start) begin
                col   <= '0;
                phase <= PHASE_C;
            end else if (line_end) begin
                oEOL <= 1'b1;
                line <= (line == V_LAST) ? '0 : line + 1'b1;
            end else if (byte_en) begin
                if (phase == PHASE_C) begin
                    c_byte <= iDATA;
                    phase  <= PHASE_Y;
                end else begin
                    phase <= PHASE_C;
                    if (col < H_MAX) begin
                        oVALID <= 1'b1;
                        oYCbCr <= {iDATA, c_byte};
                        oX     <= col;
                        oLINE  <= line;
                        oSOF   <= (col == '0) && (line == '0);
                        col    <= col + 1'b1;
                    end
                end
            end
        end
    end

    assign oBUSY = (state != IDLE);

`ifdef YUV_SEQ_STATUS_EN
    logic start_q;
    logic clr;
    logic set_short;
    logic set_long;

    assign clr       = iCLR | (iSTART & ~start_q);
    assign set_short = line_end && ((col < H_MAX) || (phase == PHASE_Y));
    assign set_long  = byte_en && (phase == PHASE_Y) && (col >= H_MAX);

    // Setting a flag takes priority over clearing it in the same cycle.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            start_q    <= 1'b0;
            oERR_SHORT <= 1'b0;
            oERR_LONG  <= 1'b0;
            oERR_ABORT <= 1'b0;
        end else begin
            start_q    <= iSTART;
            oERR_SHORT <= set_short | (oERR_SHORT & ~clr);
            oERR_LONG  <= set_long  | (oERR_LONG  & ~clr);
            oERR_ABORT <= abort     | (oERR_ABORT & ~clr);
        end
    end
`else
    logic unused_status;

    assign unused_status = iCLR;
    assign oERR_SHORT    = 1'b0;
    assign oERR_LONG     = 1'b0;
    assign oERR_ABORT    = 1'b0;
`endif

endmodule

// File: tb/tb_yuv_capture_sequencer.sv
// Randomized self-checking bench for yuv_capture_sequencer on a 4x2 frame,
// checked against a per-line arithmetic model of the expected pixel stream.
module tb_yuv_capture_sequencer;

    localparam int H = 4;
    localparam int V = 2;
`ifdef YUV_SEQ_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [9:0]  x;
        logic [9:0]  line;
        logic        sof;
    } pix_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSTART = 1'b0;
    logic        iVSYNC = 1'b0;
    logic        iHREF = 1'b0;
    logic        iDE = 1'b0;
    logic [7:0]  iDATA = 8'h00;
    logic        iCLR = 1'b0;
    logic [15:0] oYCbCr;
    logic [9:0]  oX;
    logic [9:0]  oLINE;
    logic        oVALID;
    logic        oSOF;
    logic        oEOL;
    logic        oBUSY;
    logic        oERR_SHORT;
    logic        oERR_LONG;
    logic        oERR_ABORT;

    yuv_capture_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTART     (iSTART),
        .iVSYNC     (iVSYNC),
        .iHREF      (iHREF),
        .iDE        (iDE),
        .iDATA      (iDATA),
        .iCLR       (iCLR),
        .oYCbCr     (oYCbCr),
        .oX         (oX),
        .oLINE      (oLINE),
        .oVALID     (oVALID),
        .oSOF       (oSOF),
        .oEOL       (oEOL),
        .oBUSY      (oBUSY),
        .oERR_SHORT (oERR_SHORT),
        .oERR_LONG  (oERR_LONG),
        .oERR_ABORT (oERR_ABORT)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;

    pix_t       got_q[$];
    pix_t       exp_q[$];
    int         got_eol = 0;
    int         exp_eol = 0;
    int         exp_line = 0;
    bit         exp_short = 0;
    bit         exp_long = 0;
    bit         exp_abort = 0;
    logic [7:0] line_q[$];
    logic [7:0] seq_byte = 8'h00;

    always @(negedge iCLK) begin
        if (oVALID) got_q.push_back({oYCbCr, oX, oLINE, oSOF});
        if (oEOL) got_eol++;
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Expected output of one line: every complete byte pair is a pixel, only
    // the first H are shown, and an aborted line produces no end-of-line.
    task automatic model_line(input bit aborted);
        int pixels;
        int shown;
        pix_t p;
        pixels = line_q.size() / 2;
        shown = (pixels < H) ? pixels : H;
        for (int k = 0; k < shown; k++) begin
            p.data = {line_q[2*k+1], line_q[2*k]};
            p.x    = 10'(k);
            p.line = 10'(exp_line);
            p.sof  = (k == 0) && (exp_line == 0);
            exp_q.push_back(p);
        end
        if (aborted) begin
            exp_line = 0;
            exp_abort = 1;
        end else begin
            exp_eol++;
            if (pixels < H || (line_q.size() % 2) != 0) exp_short = 1;
            if (pixels > H) exp_long = 1;
            exp_line = (exp_line + 1) % V;
        end
    endtask

    task automatic make_seq(input int n);
        line_q.delete();
        repeat (n) begin
            line_q.push_back(seq_byte);
            seq_byte = seq_byte + 8'h01;
        end
    endtask

    task automatic make_rand(input int n);
        line_q.delete();
        repeat (n) line_q.push_back(8'($urandom));
    endtask

    task automatic drive_line(input bit gaps, input bit abort_it);
        iHREF = 1'b1;
        step();
        foreach (line_q[i]) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    iDE = 1'b0;
                    iDATA = 8'($urandom);
                    step();
                end
            end
            iDE = 1'b1;
            iDATA = line_q[i];
            step();
        end
        iDE = 1'b0;
        iHREF = 1'b0;
        if (abort_it) iVSYNC = 1'b1;
        step();
        iVSYNC = 1'b0;
        idle(3);
        model_line(abort_it);
    endtask

    task automatic vsync_pulse();
        iVSYNC = 1'b1;
        step();
        iVSYNC = 1'b0;
        step();
        exp_line = 0;
    endtask

    task automatic start_capture();
        if (!iSTART) begin
            exp_short = 0;
            exp_long = 0;
            exp_abort = 0;
        end
        iSTART = 1'b1;
        step();
    endtask

    task automatic pulse_clear();
        iCLR = 1'b1;
        step();
        iCLR = 1'b0;
        exp_short = 0;
        exp_long = 0;
        exp_abort = 0;
    endtask

    task automatic check_pixels(input string name);
        int n;
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL %s pixel count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("[TB] FAIL %s pixel %0d {data,x,line,sof}: got %h/%0d/%0d/%b expected %h/%0d/%0d/%b",
                         name, i, got_q[i].data, got_q[i].x, got_q[i].line, got_q[i].sof,
                         exp_q[i].data, exp_q[i].x, exp_q[i].line, exp_q[i].sof);
            end
        end
        checks++;
        if (got_eol !== exp_eol) begin
            errors++;
            $display("[TB] FAIL %s eol count: got %0d expected %0d", name, got_eol, exp_eol);
        end
        got_q.delete();
        exp_q.delete();
        got_eol = 0;
        exp_eol = 0;
    endtask

    task automatic check_errors(input string name);
        checks++;
        if (oERR_SHORT !== (exp_short & STATUS_EN)) begin
            errors++;
            $display("[TB] FAIL %s err_short: got %b expected %b", name, oERR_SHORT, exp_short & STATUS_EN);
        end
        checks++;
        if (oERR_LONG !== (exp_long & STATUS_EN)) begin
            errors++;
            $display("[TB] FAIL %s err_long: got %b expected %b", name, oERR_LONG, exp_long & STATUS_EN);
        end
        checks++;
        if (oERR_ABORT !== (exp_abort & STATUS_EN)) begin
            errors++;
            $display("[TB] FAIL %s err_abort: got %b expected %b", name, oERR_ABORT, exp_abort & STATUS_EN);
        end
    endtask

    task automatic check_busy(input string name, input logic expected);
        checks++;
        if (oBUSY !== expected) begin
            errors++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, oBUSY, expected);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (oYCbCr !== 16'h0 || oX !== 10'h0 || oLINE !== 10'h0) begin
            errors++;
            $display("[TB] FAIL %s data/x/line: got %h/%0d/%0d expected 0/0/0", name, oYCbCr, oX, oLINE);
        end
        checks++;
        if ({oVALID, oSOF, oEOL} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL %s valid/sof/eol: got %b expected 000", name, {oVALID, oSOF, oEOL});
        end
        check_busy(name, 1'b0);
        checks++;
        if ({oERR_SHORT, oERR_LONG, oERR_ABORT} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL %s errors: got %b expected 000", name, {oERR_SHORT, oERR_LONG, oERR_ABORT});
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        idle(3);
        check_all_zero("reset");
        iRST = 1'b0;
        step();
        check_busy("idle_after_reset", 1'b0);
    endtask

    task automatic test_basic_frame();
        start_capture();
        check_busy("armed", 1'b1);
        vsync_pulse();
        seq_byte = 8'h10;
        make_seq(8);
        drive_line(1'b0, 1'b0);
        make_seq(8);
        drive_line(1'b0, 1'b0);
        check_pixels("basic_frame");
        check_errors("basic_frame");
        check_busy("rearmed", 1'b1);
    endtask

    task automatic test_long_line();
        vsync_pulse();
        make_rand(12);
        drive_line(1'b1, 1'b0);
        make_rand(8);
        drive_line(1'b1, 1'b0);
        check_pixels("long_line");
        check_errors("long_line");
    endtask

    task automatic test_short_line();
        vsync_pulse();
        make_rand(7);
        drive_line(1'b0, 1'b0);
        make_rand(8);
        drive_line(1'b0, 1'b0);
        check_pixels("short_line");
        check_errors("short_line");
    endtask

    task automatic test_clear();
        pulse_clear();
        step();
        check_errors("clear");
    endtask

    task automatic test_abort();
        vsync_pulse();
        make_rand(8);
        drive_line(1'b0, 1'b0);
        make_rand(4);
        drive_line(1'b0, 1'b1);
        make_rand(8);
        drive_line(1'b1, 1'b0);
        make_rand(8);
        drive_line(1'b1, 1'b0);
        check_pixels("abort");
        check_errors("abort");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 5; f++) begin
            pulse_clear();
            vsync_pulse();
            for (int l = 0; l < V; l++) begin
                int n;
                n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 13)) : 8;
                make_rand(n);
                drive_line(1'($urandom_range(0, 1)), 1'b0);
            end
            idle(2);
            check_pixels("random_frame");
            check_errors("random_frame");
        end
    endtask

    task automatic test_stop_midframe();
        vsync_pulse();
        make_rand(8);
        drive_line(1'b0, 1'b0);
        iSTART = 1'b0;
        check_busy("stop_midframe_running", 1'b1);
        make_rand(8);
        drive_line(1'b0, 1'b0);
        check_busy("stop_midframe_done", 1'b0);
        check_pixels("stop_midframe");
    endtask

    task automatic test_reset_midline();
        start_capture();
        vsync_pulse();
        iHREF = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            iDE = 1'b1;
            iDATA = 8'($urandom);
            step();
        end
        iRST = 1'b1;
        #1;
        check_all_zero("reset_midline");
        iSTART = 1'b0;
        iHREF = 1'b0;
        iDE = 1'b0;
        step();
        iRST = 1'b0;
        idle(2);
        check_busy("after_midline_reset", 1'b0);
        got_q.delete();
        exp_q.delete();
        got_eol = 0;
        exp_eol = 0;
        exp_line = 0;
        exp_short = 0;
        exp_long = 0;
        exp_abort = 0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_long_line();
        test_short_line();
        test_clear();
        test_abort();
        test_random_frames();
        test_stop_midframe();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
